dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester controller that shares the single-port data memory between the core load/store path (port 0) and a DMA/debug port (port 1). It arbitrates round-robin, serialises accesses, and sequences byte/halfword stores as read-modify-write, because the memory only writes full 32-bit words. It sits between both requesters and the data memory's `i_enb`/`i_wren`/`i_addr`/`i_data`/`o_data` pins. Memory read data is combinational from `i_addr`.

## Interface
- `RR_EN`, default 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.
- `i_clk` in 1: clock; all state updates on rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_cN_req` in 1 (N=0,1): request valid; held stable until `o_cN_gnt`.
- `i_cN_we` in 1: 1 = store, 0 = load.
- `i_cN_addr` in 14: byte address; bits [1:0] ignored for word selection.
- `i_cN_wdata` in 32: store data, already lane-aligned.
- `i_cN_be` in 4: byte enables for stores; bit k covers bits [8k+7:8k].
- `o_cN_gnt` out 1: one-cycle accept pulse; request fields are captured in that cycle.
- `o_cN_rvalid` out 1: one-cycle load-data-valid pulse.
- `o_cN_rdata` out 32: load data; holds its value until the next load on the same port.
- `o_mem_enb` out 1: to memory `i_enb`.
- `o_mem_wren` out 1: to memory `i_wren`.
- `o_mem_addr` out 14: to memory `i_addr`.
- `o_mem_wdata` out 32: to memory `i_data`.
- `i_mem_rdata` in 32: from memory `o_data`.
- `o_busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, WRBACK.
- **IDLE**
  - If any `req` is high, select a winner and assert its `gnt` combinationally.
  - Latch `we`, `addr`, `wdata`, `be` and the port id; go to ACCESS.
  - With no request, stay in IDLE.
- **Arbitration**
  - With `RR_EN=1`, the priority pointer starts at port 0 after reset.
  - After each grant, the pointer moves to the other port.
  - With one requester active, that requester wins regardless of the pointer.
- **ACCESS**
  - `o_mem_enb=1`, `o_mem_addr` = latched addr.
  - Load: `o_cN_rdata <= i_mem_rdata`, `o_cN_rvalid <= 1` for the granted port only; go to IDLE.
  - Store, `be=4'hF`: `o_mem_wren=1`, `o_mem_wdata` = wdata; go to IDLE.
  - Store, `be=4'h0`: no write (`o_mem_wren=0`); go to IDLE.
  - Store, partial `be`: no write. Merge register ← per byte (`be[k]` ? wdata byte : `i_mem_rdata` byte); go to WRBACK.
- **WRBACK**
  - `o_mem_enb=1`, `o_mem_wren=1`, same addr, `o_mem_wdata` = merge register; go to IDLE.
- Only one port sees `gnt` or `rvalid` in any cycle.
- Accesses complete in grant order. A load following a store to the same word, from either port, returns the stored data.
- In IDLE, `o_mem_enb=0`, `o_mem_wren=0`, and addr/wdata hold their last values.

## Timing
- Reset values:
  - State IDLE, pointer = port 0.
  - All `gnt`, `rvalid`, `o_mem_enb`, `o_mem_wren`, `o_busy` = 0.
  - `o_cN_rdata`, `o_mem_addr`, `o_mem_wdata`, merge register = 0.
- `o_mem_wren` is gated by `!i_rst`: no memory write in a reset cycle.
- Reset in ACCESS or WRBACK aborts the transaction:
  - A pending RMW write is dropped.
  - No `rvalid` is issued.
- Load latency: `gnt` at cycle T, memory read at T+1, `rvalid`/`rdata` visible at T+2.
- Full-word or `be=0` store: `gnt` at T, write edge ends T+1, next `gnt` possible at T+2.
- Partial store: `gnt` at T, read at T+1, write at T+2, next `gnt` possible at T+3.
- Load throughput is one access per 2 cycles. `rvalid` of one load coincides with the next `gnt` in IDLE.
- A request arriving while the FSM is not in IDLE waits. `req` must stay high; dropping `req` before `gnt` withdraws the request.
- `gnt` depends combinationally on `req` in IDLE only.

## Test plan
- Reset, then a port 0 load of addr 0x010 after the memory is preloaded with 0xDEADBEEF at word 4. Required: `gnt0` at T, `rvalid0` at T+2, `rdata0`=0xDEADBEEF, `rvalid1` stays 0.
- Port 1 store of 0x11223344 to addr 0x020 with `be`=4'b0010 over the old word 0xAABBCCDD. Required:
  - ACCESS cycle has wren=0; WRBACK writes 0xAABB33DD.
  - A subsequent port 0 load of addr 0x020 returns 0xAABB33DD.
- Both ports request loads continuously with `RR_EN=1`. Required: grants alternate 0,1,0,1 at cycles T, T+2, T+4, T+6.
- Repeat the previous scenario with `RR_EN=0`. Required: port 0 granted every 2 cycles; port 1 never granted while `req0` is high.
- Partial store with `i_rst` asserted in the WRBACK cycle. Required:
  - No memory write; memory word unchanged.
  - All outputs at reset values the next cycle.
  - FSM in IDLE.
- Store with `be`=4'h0 to addr 0x030 holding 0x12345678. Required: `o_mem_wren` never high, word unchanged, FSM back in IDLE at T+2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: round-robin or fixed
// priority grant, serialised accesses, and read-modify-write for sub-word stores.
module dmem_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_c0_req,
    input  logic        i_c0_we,
    input  logic [13:0] i_c0_addr,
    input  logic [31:0] i_c0_wdata,
    input  logic [3:0]  i_c0_be,
    output logic        o_c0_gnt,
    output logic        o_c0_rvalid,
    output logic [31:0] o_c0_rdata,
    input  logic        i_c1_req,
    input  logic        i_c1_we,
    input  logic [13:0] i_c1_addr,
    input  logic [31:0] i_c1_wdata,
    input  logic [3:0]  i_c1_be,
    output logic        o_c1_gnt,
    output logic        o_c1_rvalid,
    output logic [31:0] o_c1_rdata,
    output logic        o_mem_enb,
    output logic        o_mem_wren,
    output logic [13:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRBACK} state_t;

    state_t      state, state_nxt;
    logic        ptr;
    logic        win;
    logic        port_p0;
    logic        we_p0;
    logic [13:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  be_p0;
    logic [31:0] merge_p1;
    logic [31:0] wdata_hold;
    logic [31:0] mem_wdata;
    logic        partial;

    function automatic logic [31:0] merge_bytes(input logic [31:0] wd,
                                                input logic [31:0] rd,
                                                input logic [3:0]  be);
        logic [31:0] m;
        for (int k = 0; k < 4; k++)
            m[8*k +: 8] = be[k] ? wd[8*k +: 8] : rd[8*k +: 8];
        return m;
    endfunction

    assign partial = we_p0 && (be_p0 != 4'hF) && (be_p0 != 4'h0);

    always_comb begin
        state_nxt = state;
        win       = 1'b0;
        o_c0_gnt  = 1'b0;
        o_c1_gnt  = 1'b0;
        case (state)
            IDLE: begin
                if (!i_rst && (i_c0_req || i_c1_req)) begin
                    // Pointer only matters when both ports contend
                    if (i_c0_req && i_c1_req)
                        win = RR_EN ? ptr : 1'b0;
                    else
                        win = i_c1_req;
                    o_c0_gnt  = !win;
                    o_c1_gnt  = win;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = partial ? WRBACK : IDLE;
            WRBACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (state)
            ACCESS:  mem_wdata = wdata_p0;
            WRBACK:  mem_wdata = merge_p1;
            default: mem_wdata = wdata_hold;
        endcase
    end

    assign o_mem_enb   = (state != IDLE);
    assign o_mem_wren  = !i_rst && ((state == ACCESS && we_p0 && be_p0 == 4'hF) ||
                                    (state == WRBACK));
    assign o_mem_addr  = addr_p0;
    assign o_mem_wdata = mem_wdata;
    assign o_busy      = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            port_p0     <= 1'b0;
            we_p0       <= 1'b0;
            addr_p0     <= '0;
            wdata_p0    <= '0;
            be_p0       <= '0;
            merge_p1    <= '0;
            wdata_hold  <= '0;
            o_c0_rvalid <= 1'b0;
            o_c1_rvalid <= 1'b0;
            o_c0_rdata  <= '0;
            o_c1_rdata  <= '0;
        end else begin
            state       <= state_nxt;
            o_c0_rvalid <= 1'b0;
            o_c1_rvalid <= 1'b0;
            // Stage p0: capture the granted request
            if (o_c0_gnt || o_c1_gnt) begin
                port_p0  <= o_c1_gnt;
                we_p0    <= o_c1_gnt ? i_c1_we    : i_c0_we;
                addr_p0  <= o_c1_gnt ? i_c1_addr  : i_c0_addr;
                wdata_p0 <= o_c1_gnt ? i_c1_wdata : i_c0_wdata;
                be_p0    <= o_c1_gnt ? i_c1_be    : i_c0_be;
                ptr      <= o_c0_gnt;
            end
            // Stage p1: memory access, load return or byte merge
            if (state == ACCESS) begin
                if (!we_p0) begin
                    if (port_p0) begin
                        o_c1_rdata  <= i_mem_rdata;
                        o_c1_rvalid <= 1'b1;
                    end else begin
                        o_c0_rdata  <= i_mem_rdata;
                        o_c0_rvalid <= 1'b1;
                    end
                end else if (partial) begin
                    merge_p1 <= merge_bytes(wdata_p0, i_mem_rdata, be_p0);
                end
            end
            // Keep the last driven write data visible while idle
            if (state != IDLE)
                wdata_hold <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one round-robin and one fixed-priority
// instance share stimulus, each backed by its own word memory model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        c0_req, c0_we, c1_req, c1_we;
    logic [13:0] c0_addr, c1_addr;
    logic [31:0] c0_wdata, c1_wdata;
    logic [3:0]  c0_be, c1_be;

    logic        a_gnt0, a_gnt1, a_rv0, a_rv1, a_enb, a_wren, a_busy;
    logic [31:0] a_rd0, a_rd1, a_wdata, a_mrd;
    logic [13:0] a_addr;
    logic        b_gnt0, b_gnt1, b_rv0, b_rv1, b_enb, b_wren, b_busy;
    logic [31:0] b_rd0, b_rd1, b_wdata, b_mrd;
    logic [13:0] b_addr;

    logic [31:0] mem_a [4096];
    logic [31:0] mem_b [4096];
    logic        pre_en;
    logic [11:0] pre_idx;
    logic [31:0] pre_val;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_arbiter #(.RR_EN(1'b1)) dut_rr (
        .i_clk(clk), .i_rst(rst),
        .i_c0_req(c0_req), .i_c0_we(c0_we), .i_c0_addr(c0_addr),
        .i_c0_wdata(c0_wdata), .i_c0_be(c0_be),
        .o_c0_gnt(a_gnt0), .o_c0_rvalid(a_rv0), .o_c0_rdata(a_rd0),
        .i_c1_req(c1_req), .i_c1_we(c1_we), .i_c1_addr(c1_addr),
        .i_c1_wdata(c1_wdata), .i_c1_be(c1_be),
        .o_c1_gnt(a_gnt1), .o_c1_rvalid(a_rv1), .o_c1_rdata(a_rd1),
        .o_mem_enb(a_enb), .o_mem_wren(a_wren), .o_mem_addr(a_addr),
        .o_mem_wdata(a_wdata), .i_mem_rdata(a_mrd), .o_busy(a_busy)
    );

    dmem_arbiter #(.RR_EN(1'b0)) dut_fp (
        .i_clk(clk), .i_rst(rst),
        .i_c0_req(c0_req), .i_c0_we(c0_we), .i_c0_addr(c0_addr),
        .i_c0_wdata(c0_wdata), .i_c0_be(c0_be),
        .o_c0_gnt(b_gnt0), .o_c0_rvalid(b_rv0), .o_c0_rdata(b_rd0),
        .i_c1_req(c1_req), .i_c1_we(c1_we), .i_c1_addr(c1_addr),
        .i_c1_wdata(c1_wdata), .i_c1_be(c1_be),
        .o_c1_gnt(b_gnt1), .o_c1_rvalid(b_rv1), .o_c1_rdata(b_rd1),
        .o_mem_enb(b_enb), .o_mem_wren(b_wren), .o_mem_addr(b_addr),
        .o_mem_wdata(b_wdata), .i_mem_rdata(b_mrd), .o_busy(b_busy)
    );

    assign a_mrd = mem_a[a_addr[13:2]];
    assign b_mrd = mem_b[b_addr[13:2]];

    always @(posedge clk) begin
        if (pre_en) begin
            mem_a[pre_idx] <= pre_val;
            mem_b[pre_idx] <= pre_val;
        end else begin
            if (a_enb && a_wren) mem_a[a_addr[13:2]] <= a_wdata;
            if (b_enb && b_wren) mem_b[b_addr[13:2]] <= b_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic preload(input logic [11:0] idx, input logic [31:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        cyc();
        pre_en = 1'b0;
    endtask

    task automatic drive0(input logic we, input logic [13:0] addr,
                          input logic [31:0] wd, input logic [3:0] be);
        c0_req = 1'b1; c0_we = we; c0_addr = addr; c0_wdata = wd; c0_be = be;
    endtask

    task automatic drive1(input logic we, input logic [13:0] addr,
                          input logic [31:0] wd, input logic [3:0] be);
        c1_req = 1'b1; c1_we = we; c1_addr = addr; c1_wdata = wd; c1_be = be;
    endtask

    initial begin
        rst = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0; c0_be = '0;
        c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0; c1_be = '0;
        repeat (2) cyc();
        preload(12'd4,  32'hDEADBEEF);
        preload(12'd8,  32'hAABBCCDD);
        preload(12'd12, 32'h12345678);
        preload(12'd16, 32'h55667788);

        // Reset state, including a request presented during reset
        c0_req = 1'b1;
        #1;
        chk("rst_gnt0", a_gnt0, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_enb", a_enb, 0);
        chk("rst_wren", a_wren, 0);
        chk("rst_rv0", a_rv0, 0);
        chk("rst_rd0", a_rd0, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_wdata", a_wdata, 0);
        c0_req = 1'b0;
        cyc(); rst = 1'b0;

        // Port 0 load of word 4
        cyc(); drive0(1'b0, 14'h010, 32'h0, 4'h0);
        #1; chk("t1_gnt0", a_gnt0, 1); chk("t1_gnt1", a_gnt1, 0);
        cyc(); c0_req = 1'b0;
        #1; chk("t1_busy", a_busy, 1); chk("t1_enb", a_enb, 1);
        chk("t1_addr", a_addr, 14'h010); chk("t1_rv0_early", a_rv0, 0);
        cyc();
        #1; chk("t1_rv0", a_rv0, 1); chk("t1_rd0", a_rd0, 32'hDEADBEEF);
        chk("t1_rv1", a_rv1, 0); chk("t1_idle", a_busy, 0);
        cyc();
        #1; chk("t1_rv0_pulse", a_rv0, 0); chk("t1_rd0_hold", a_rd0, 32'hDEADBEEF);

        // Port 1 partial store, byte 1, over 0xAABBCCDD
        cyc(); drive1(1'b1, 14'h020, 32'h11223344, 4'b0010);
        #1; chk("t2_gnt1", a_gnt1, 1); chk("t2_gnt0", a_gnt0, 0);
        cyc(); c1_req = 1'b0;
        #1; chk("t2_acc_enb", a_enb, 1); chk("t2_acc_wren", a_wren, 0);
        cyc();
        #1; chk("t2_wb_wren", a_wren, 1); chk("t2_wb_wdata", a_wdata, 32'hAABB33DD);
        chk("t2_wb_addr", a_addr, 14'h020);
        cyc();
        #1; chk("t2_idle_wren", a_wren, 0); chk("t2_idle", a_busy, 0);
        chk("t2_wdata_hold", a_wdata, 32'hAABB33DD);
        chk("t2_mem", mem_a[8], 32'hAABB33DD);
        cyc(); drive0(1'b0, 14'h020, 32'h0, 4'h0);
        #1; chk("t2_ld_gnt0", a_gnt0, 1);
        cyc(); c0_req = 1'b0;
        cyc();
        #1; chk("t2_ld_rv0", a_rv0, 1); chk("t2_ld_rd0", a_rd0, 32'hAABB33DD);

        // Full-word store issued in the rvalid cycle, then a load right behind it
        drive1(1'b1, 14'h050, 32'hCAFEF00D, 4'hF);
        #1; chk("t3_gnt1", a_gnt1, 1);
        cyc(); c1_req = 1'b0;
        #1; chk("t3_wren", a_wren, 1); chk("t3_wdata", a_wdata, 32'hCAFEF00D);
        chk("t3_addr", a_addr, 14'h050);
        cyc(); drive0(1'b0, 14'h050, 32'h0, 4'h0);
        #1; chk("t3_next_gnt0", a_gnt0, 1); chk("t3_wren_off", a_wren, 0);
        cyc(); c0_req = 1'b0;
        cyc();
        #1; chk("t3_rd0", a_rd0, 32'hCAFEF00D);

        // Continuous contention after reset: round-robin vs fixed priority
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        drive0(1'b0, 14'h010, 32'h0, 4'h0);
        drive1(1'b0, 14'h020, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rr_gnt0_%0d", k), a_gnt0, (k % 4) == 0);
            chk($sformatf("rr_gnt1_%0d", k), a_gnt1, (k % 4) == 2);
            chk($sformatf("fp_gnt0_%0d", k), b_gnt0, (k % 2) == 0);
            chk($sformatf("fp_gnt1_%0d", k), b_gnt1, 0);
            chk($sformatf("fp_rv1_%0d", k), b_rv1, 0);
            if (k == 0) chk("rr_rd0_cleared", a_rd0, 0);
            if (k == 2) begin
                chk("rr_rv0", a_rv0, 1); chk("rr_rd0", a_rd0, 32'hDEADBEEF);
                chk("fp_rv0", b_rv0, 1); chk("fp_rd0", b_rd0, 32'hDEADBEEF);
            end
            if (k == 4) begin
                chk("rr_rv1", a_rv1, 1); chk("rr_rd1", a_rd1, 32'hAABB33DD);
            end
            cyc();
        end
        c0_req = 1'b0; c1_req = 1'b0;
        cyc(); cyc();
        #1; chk("fp_rd1_never", b_rd1, 0); chk("fp_idle", b_busy, 0);

        // Partial store with reset in the write-back cycle
        cyc(); drive0(1'b1, 14'h040, 32'h000000AA, 4'b0001);
        #1; chk("t5_gnt0", a_gnt0, 1);
        cyc(); c0_req = 1'b0;
        #1; chk("t5_acc_wren", a_wren, 0);
        cyc(); rst = 1'b1;
        #1; chk("t5_wb_state", a_busy, 1); chk("t5_wb_wren", a_wren, 0);
        cyc(); rst = 1'b0;
        #1;
        chk("t5_busy", a_busy, 0); chk("t5_enb", a_enb, 0); chk("t5_wren", a_wren, 0);
        chk("t5_rv0", a_rv0, 0); chk("t5_rv1", a_rv1, 0);
        chk("t5_rd0", a_rd0, 0); chk("t5_rd1", a_rd1, 0);
        chk("t5_addr", a_addr, 0); chk("t5_wdata", a_wdata, 0);
        chk("t5_gnt0", a_gnt0, 0); chk("t5_mem", mem_a[16], 32'h55667788);

        // Store with no byte enables
        cyc(); drive0(1'b1, 14'h030, 32'hFFFFFFFF, 4'h0);
        #1; chk("t6_gnt0", a_gnt0, 1); chk("t6_wren_t0", a_wren, 0);
        cyc(); c0_req = 1'b0;
        #1; chk("t6_wren_t1", a_wren, 0); chk("t6_busy_t1", a_busy, 1);
        chk("t6_enb_t1", a_enb, 1);
        cyc();
        #1; chk("t6_idle_t2", a_busy, 0); chk("t6_wren_t2", a_wren, 0);
        chk("t6_mem", mem_a[12], 32'h12345678);
        chk("fp_mem_merge", mem_b[8], 32'hAABB33DD);

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
